// File: rtl/maze_game_ctrl.sv
// Maze game controller: player square movement, wall/finish collision, lives,
// two-level progression and composite pixel colour for a VGA-style raster.
module maze_game_ctrl #(
    parameter int START_X = 40,
    parameter int START_Y = 465,
    parameter int PSIZE   = 10,
    parameter int STEP    = 2,
    parameter int HOLD    = 60
) (
    input  logic        pixel_clk,
    input  logic        resetSwitch,
    input  logic [9:0]  col,
    input  logic [8:0]  row,
    input  logic        frame_tick,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_start,
    input  logic [11:0] lvl0_rgb,
    input  logic [11:0] lvl1_rgb,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        level_sel,
    output logic [1:0]  lives,
    output logic [2:0]  state
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PLAY = 3'd1,
        S_FAIL = 3'd2,
        S_WIN  = 3'd3,
        S_OVER = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [9:0] X_MAX = 10'd629;
    localparam logic [8:0] Y_MAX = 9'd469;

    state_t      r_state;
    logic [9:0]  r_px;
    logic [8:0]  r_py;
    logic [1:0]  r_lives;
    logic        r_level;
    logic        r_hit_fin;
    logic        r_hit_wall;
    logic [5:0]  r_hold;
    logic        r_start_prev;
    logic        r_in_sq_d;
    logic [11:0] r_rgb;

    logic [11:0] w_lvl_rgb;
    logic [10:0] w_px_end;
    logic [9:0]  w_py_end;
    logic        w_in_sq;
    logic [9:0]  w_px_nxt;
    logic [8:0]  w_py_nxt;

    assign w_lvl_rgb = r_level ? lvl1_rgb : lvl0_rgb;
    assign w_px_end  = {1'b0, r_px} + 11'(PSIZE);
    assign w_py_end  = {1'b0, r_py} + 10'(PSIZE);
    assign w_in_sq   = ({1'b0, col} >= {1'b0, r_px}) && ({1'b0, col} < w_px_end) &&
                       ({1'b0, row} >= {1'b0, r_py}) && ({1'b0, row} < w_py_end);

    // Single-direction move with saturation at the playfield edges.
    always_comb begin
        w_px_nxt = r_px;
        w_py_nxt = r_py;
        if (btn_up)
            w_py_nxt = (r_py < 9'(STEP)) ? 9'd0 : r_py - 9'(STEP);
        else if (btn_down)
            w_py_nxt = (r_py > Y_MAX - 9'(STEP)) ? Y_MAX : r_py + 9'(STEP);
        else if (btn_left)
            w_px_nxt = (r_px < 10'(STEP)) ? 10'd0 : r_px - 10'(STEP);
        else if (btn_right)
            w_px_nxt = (r_px > X_MAX - 10'(STEP)) ? X_MAX : r_px + 10'(STEP);
    end

    always_ff @(posedge pixel_clk or posedge resetSwitch) begin
        if (resetSwitch) begin
            r_state      <= S_IDLE;
            r_px         <= 10'(START_X);
            r_py         <= 9'(START_Y);
            r_lives      <= 2'd3;
            r_level      <= 1'b0;
            r_hit_fin    <= 1'b0;
            r_hit_wall   <= 1'b0;
            r_hold       <= 6'd0;
            r_start_prev <= 1'b0;
            r_in_sq_d    <= 1'b0;
            r_rgb        <= 12'h000;
        end else begin
            r_start_prev <= btn_start;
            r_in_sq_d    <= w_in_sq;

            // Flags decide the current frame's outcome, then restart for the next frame.
            if (frame_tick) begin
                r_hit_fin  <= 1'b0;
                r_hit_wall <= 1'b0;
            end else if (r_state == S_PLAY && r_in_sq_d) begin
                if (w_lvl_rgb == 12'hF00) r_hit_fin  <= 1'b1;
                if (w_lvl_rgb == 12'h000) r_hit_wall <= 1'b1;
            end

            case (r_state)
                S_IDLE: if (btn_start && !r_start_prev) r_state <= S_PLAY;
                S_PLAY: if (frame_tick) begin
                    if (r_hit_fin) begin
                        r_state <= S_WIN;
                        r_hold  <= 6'd0;
                    end else if (r_hit_wall) begin
                        r_state <= S_FAIL;
                        r_hold  <= 6'd0;
                    end else begin
                        r_px <= w_px_nxt;
                        r_py <= w_py_nxt;
                    end
                end
                S_FAIL: if (frame_tick) begin
                    if (r_hold == 6'(HOLD - 1)) begin
                        r_lives <= r_lives - 2'd1;
                        r_px    <= 10'(START_X);
                        r_py    <= 9'(START_Y);
                        r_state <= (r_lives == 2'd1) ? S_OVER : S_IDLE;
                    end else begin
                        r_hold <= r_hold + 6'd1;
                    end
                end
                S_WIN: if (frame_tick) begin
                    if (r_hold == 6'(HOLD - 1)) begin
                        if (r_level) begin
                            r_state <= S_DONE;
                        end else begin
                            r_level <= 1'b1;
                            r_px    <= 10'(START_X);
                            r_py    <= 9'(START_Y);
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_hold <= r_hold + 6'd1;
                    end
                end
                default: r_state <= r_state;
            endcase

            if (r_state == S_OVER)
                r_rgb <= 12'hF00;
            else if (r_state == S_DONE)
                r_rgb <= 12'h0F0;
            else if (r_in_sq_d && r_state == S_FAIL)
                r_rgb <= r_hold[3] ? 12'hF00 : 12'h000;
            else if (r_in_sq_d && r_state == S_WIN)
                r_rgb <= 12'hFF0;
            else if (r_in_sq_d)
                r_rgb <= 12'h00F;
            else
                r_rgb <= w_lvl_rgb;
        end
    end

    assign red       = r_rgb[11:8];
    assign green     = r_rgb[7:4];
    assign blue      = r_rgb[3:0];
    assign level_sel = r_level;
    assign lives     = r_lives;
    assign state     = r_state;
endmodule

// File: tb/tb_maze_game_ctrl.sv
// Directed bench for maze_game_ctrl: player position is observed through the
// square colour on probed pixels; expected values are hand-derived constants.
module tb_maze_game_ctrl;
    logic        pixel_clk = 1'b0;
    logic        resetSwitch = 1'b1;
    logic [9:0]  col = 10'd639;
    logic [8:0]  row = 9'd479;
    logic        frame_tick = 1'b0;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic        btn_start = 1'b0;
    logic [11:0] lvl0_rgb = 12'hFFF, lvl1_rgb = 12'hFFF;
    logic [3:0]  red, green, blue;
    logic        level_sel;
    logic [1:0]  lives;
    logic [2:0]  state;

    int errors = 0;
    int checks = 0;
    logic [11:0] pix;

    maze_game_ctrl dut (
        .pixel_clk(pixel_clk), .resetSwitch(resetSwitch), .col(col), .row(row),
        .frame_tick(frame_tick), .btn_up(btn_up), .btn_down(btn_down),
        .btn_left(btn_left), .btn_right(btn_right), .btn_start(btn_start),
        .lvl0_rgb(lvl0_rgb), .lvl1_rgb(lvl1_rgb), .red(red), .green(green),
        .blue(blue), .level_sel(level_sel), .lives(lives), .state(state)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            tick();
        end
    endtask

    // Colour output for one pixel, two cycles after driving its coordinate.
    task automatic probe(input int x, input int y, output logic [11:0] o);
        col = 10'(x);
        row = 9'(y);
        tick();
        tick();
        o = {red, green, blue};
        col = 10'd639;
        row = 9'd479;
    endtask

    task automatic check_pos(input string tag, input int x, input int y);
        probe(x, y, pix);           chk({tag, " tl_in"}, 32'(pix), 32'h00F);
        probe(x + 9, y + 9, pix);   chk({tag, " br_in"}, 32'(pix), 32'h00F);
        probe(x + 10, y, pix);      chk({tag, " right_out"}, 32'(pix), 32'hFFF);
        if (x > 0) begin
            probe(x - 1, y, pix);   chk({tag, " left_out"}, 32'(pix), 32'hFFF);
        end
        if (y > 0) begin
            probe(x, y - 1, pix);   chk({tag, " top_out"}, 32'(pix), 32'hFFF);
        end
        probe(x, y + 10, pix);      chk({tag, " bottom_out"}, 32'(pix), 32'hFFF);
    endtask

    // Present colour c under the square pixel (x,y) long enough for the pipeline.
    task automatic paint(input int x, input int y, input logic [11:0] c);
        col = 10'(x);
        row = 9'(y);
        lvl0_rgb = c;
        lvl1_rgb = c;
        tick();
        tick();
    endtask

    task automatic unpaint();
        col = 10'd639;
        row = 9'd479;
        lvl0_rgb = 12'hFFF;
        lvl1_rgb = 12'hFFF;
        tick();
    endtask

    task automatic press_start();
        btn_start = 1'b0;
        tick();
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
    endtask

    task automatic do_reset();
        resetSwitch = 1'b1;
        tick();
        resetSwitch = 1'b0;
        tick();
    endtask

    initial begin
        tick();
        tick();
        chk("rst state", 32'(state), 32'd0);
        chk("rst lives", 32'(lives), 32'd3);
        chk("rst level", 32'(level_sel), 32'd0);
        chk("rst rgb", 32'({red, green, blue}), 32'h000);
        resetSwitch = 1'b0;
        tick();
        check_pos("idle_start", 40, 465);

        btn_start = 1'b1;
        tick();
        chk("start edge", 32'(state), 32'd1);
        btn_right = 1'b1;
        frames(5);
        btn_right = 1'b0;
        chk("play after move", 32'(state), 32'd1);
        check_pos("right5", 50, 465);

        paint(50, 465, 12'h000);
        unpaint();
        frames(1);
        chk("wall->fail", 32'(state), 32'd2);
        probe(52, 468, pix);
        chk("fail blink off", 32'(pix), 32'h000);
        btn_up = 1'b1;
        frames(8);
        btn_up = 1'b0;
        probe(52, 468, pix);
        chk("fail blink on", 32'(pix), 32'hF00);
        frames(51);
        chk("fail hold 59", 32'(state), 32'd2);
        frames(1);
        chk("fail exit state", 32'(state), 32'd0);
        chk("fail exit lives", 32'(lives), 32'd2);
        check_pos("fail_restore", 40, 465);

        for (int k = 0; k < 2; k++) begin
            press_start();
            paint(40, 465, 12'h000);
            unpaint();
            frames(60);
            chk("fail more state", 32'(state), 32'd2);
            frames(1);
        end
        chk("over lives", 32'(lives), 32'd0);
        chk("over state", 32'(state), 32'd4);
        probe(0, 0, pix);
        chk("over pix0", 32'(pix), 32'hF00);
        probe(639, 479, pix);
        chk("over pix1", 32'(pix), 32'hF00);
        press_start();
        chk("over sticky", 32'(state), 32'd4);

        do_reset();
        chk("rst2 lives", 32'(lives), 32'd3);
        press_start();
        paint(40, 465, 12'hF00);
        paint(41, 465, 12'h000);
        unpaint();
        frames(1);
        chk("both->win", 32'(state), 32'd3);
        probe(45, 470, pix);
        chk("win square", 32'(pix), 32'hFF0);
        frames(59);
        chk("win hold 59", 32'(state), 32'd3);
        frames(1);
        chk("win1 state", 32'(state), 32'd0);
        chk("win1 level", 32'(level_sel), 32'd1);
        chk("win1 lives", 32'(lives), 32'd3);
        check_pos("win_restore", 40, 465);
        press_start();
        paint(40, 465, 12'hF00);
        unpaint();
        frames(61);
        chk("done state", 32'(state), 32'd5);
        probe(10, 10, pix);
        chk("done pix", 32'(pix), 32'h0F0);

        do_reset();
        press_start();
        btn_right = 1'b1;
        frames(294);
        btn_right = 1'b0;
        check_pos("x628", 628, 465);
        btn_right = 1'b1;
        frames(1);
        btn_right = 1'b0;
        check_pos("x629", 629, 465);
        btn_right = 1'b1;
        frames(2);
        btn_right = 1'b0;
        check_pos("x629 sat", 629, 465);
        btn_up = 1'b1;
        btn_left = 1'b1;
        frames(1);
        btn_up = 1'b0;
        btn_left = 1'b0;
        check_pos("up_over_left", 629, 463);
        btn_down = 1'b1;
        frames(4);
        btn_down = 1'b0;
        check_pos("y469 sat", 629, 469);

        do_reset();
        press_start();
        paint(40, 465, 12'h000);
        unpaint();
        frames(61);
        chk("pre mid lives", 32'(lives), 32'd2);
        press_start();
        paint(40, 465, 12'hF00);
        unpaint();
        frames(31);
        chk("mid win state", 32'(state), 32'd3);
        col = 10'd45;
        row = 9'd470;
        tick();
        tick();
        chk("mid win pix", 32'({red, green, blue}), 32'hFF0);
        #2;
        resetSwitch = 1'b1;
        #1;
        chk("async state", 32'(state), 32'd0);
        chk("async lives", 32'(lives), 32'd3);
        chk("async level", 32'(level_sel), 32'd0);
        chk("async rgb", 32'({red, green, blue}), 32'h000);
        tick();
        resetSwitch = 1'b0;
        col = 10'd639;
        row = 9'd479;
        tick();
        probe(45, 470, pix);
        chk("post rst pix", 32'(pix), 32'h00F);
        chk("post rst state", 32'(state), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/maze_game_ctrl.md
MAZE_GAME_CTRL -- requirements
Module: maze_game_ctrl

Interface
REQ-001 SHALL have port pixel_clk, input, 1: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port resetSwitch, input, 1: reset, asynchronous, active-high.
REQ-003 SHALL have ports col (input, 10) and row (input, 9): current pixel coordinate.
REQ-004 SHALL have port frame_tick, input, 1: one-cycle pulse after the last visible pixel of each frame.
REQ-005 SHALL have ports btn_up, btn_down, btn_left, btn_right, btn_start, input, 1 each: pre-synchronized, active-high levels.
REQ-006 SHALL have ports lvl0_rgb and lvl1_rgb, input, 12 each: {r,g,b} from the two level renderers, valid one cycle after the col/row that produced them.
REQ-007 SHALL have ports red, green, blue, output, 4 each: registered composite pixel colour.
REQ-008 SHALL have ports level_sel (output, 1: active level), lives (output, 2) and state (output, 3: FSM encoding below).
REQ-009 SHALL have parameters START_X=40 (player reset x), START_Y=465 (player reset y), PSIZE=10 (square side), STEP=2 (pixels per frame), HOLD=60 (frames in WIN/FAIL).

Function
REQ-010 SHALL encode FSM states IDLE=0, PLAY=1, FAIL=2, WIN=3, OVER=4, DONE=5.
REQ-011 SHALL hold player position px (10 b) and py (9 b); the player square covers px..px+PSIZE-1 and py..py+PSIZE-1.
REQ-012 SHALL select lvl_rgb = level_sel ? lvl1_rgb : lvl0_rgb.
REQ-013 SHALL compute in_sq from col/row, delay it one cycle, and pair it with lvl_rgb of the same pixel.
REQ-014 SHALL, in PLAY, set hit_fin when the delayed in_sq is 1 and lvl_rgb==12'hF00, and set hit_wall when the delayed in_sq is 1 and lvl_rgb==12'h000.
REQ-015 SHALL clear both flags on the cycle after frame_tick.
REQ-016 SHALL leave the flags unchanged by pixels coloured 12'hFFF (path), 12'h0F0 (start) or any other colour.
REQ-017 SHALL, in IDLE, move to PLAY on a rising edge of btn_start (edge detected with a registered previous value).
REQ-018 SHALL, in PLAY on frame_tick, go to WIN if hit_fin, else to FAIL if hit_wall, else apply movement; when hit_fin and hit_wall are both set, WIN wins.
REQ-019 SHALL move the player by STEP per frame_tick in one direction only, priority up>down>left>right.
REQ-020 SHALL clamp movement to px in 0..629 and py in 0..469; a move that would cross a bound SHALL saturate at the bound.
REQ-021 SHALL count frame_tick in a 6-bit hold counter, cleared on entering FAIL or WIN; when it reaches HOLD-1, exit occurs on that frame_tick.
REQ-022 SHALL, on FAIL exit, decrement lives and restore (px,py)=(START_X,START_Y); go to OVER if lives was 1, else to IDLE.
REQ-023 SHALL, on WIN exit, go to DONE if level_sel==1; otherwise set level_sel=1, restore the start position and go to IDLE.
REQ-024 SHALL treat OVER and DONE as terminal, left only by reset.
REQ-025 SHALL ignore buttons in FAIL, WIN, OVER and DONE.
REQ-026 SHALL register outputs one cycle after lvl_rgb, giving a total latency of 2 cycles from col/row.
REQ-027 SHALL select the output colour in this priority order:
- OVER: 12'hF00 everywhere.
- DONE: 12'h0F0 everywhere.
- Delayed in_sq in FAIL: 12'hF00 when hold counter bit3=1, else 12'h000.
- Delayed in_sq in WIN: 12'hFF0.
- Delayed in_sq otherwise: 12'h00F.
- Else: lvl_rgb.

Reset
REQ-028 SHALL, while resetSwitch=1, immediately force state=IDLE, level_sel=0, lives=3, px=START_X, py=START_Y, flags=0, hold counter=0, btn_start edge register=0, delayed in_sq=0 and red/green/blue=0, including mid-frame or mid-hold.

Verification
REQ-029 Bench SHALL cover: reset, then btn_start 0->1 -> state IDLE->PLAY; btn_right held for 5 frame_ticks -> px=50, py=465.
REQ-030 Bench SHALL cover: PLAY with lvl0_rgb=000 under the square for one frame -> FAIL at frame_tick; after 60 frame_ticks -> lives=2, (px,py)=(40,465), state IDLE.
REQ-031 Bench SHALL cover: three wall hits -> lives 3->2->1->0, state OVER, output 12'hF00 on every pixel.
REQ-032 Bench SHALL cover: F00 and 000 both under the square in the same frame -> WIN, not FAIL; after 60 frames -> level_sel=1, state IDLE; a second WIN -> DONE, output 12'h0F0.
REQ-033 Bench SHALL cover: px=628 with btn_right held -> px=629 and no further change; btn_up and btn_left together -> only py decrements.
REQ-034 Bench SHALL cover: resetSwitch asserted mid-WIN hold, hold counter=30 -> all REQ-028 values immediately; pixel at col=45,row=470 -> red/green/blue=0,0,F two cycles later.
